// File: rtl/indication_pkg.sv
// Shared definitions for the indication pipe: message layout and a reusable
// round-robin picker for arbiters of up to RR_MAX_REQ requesters.
package indication_pkg;

    localparam int unsigned INDICATION_WIDTH = 96;
    localparam int unsigned METHOD_ID_MSB    = 31;
    localparam int unsigned METHOD_ID_LSB    = 0;

    localparam int unsigned RR_MAX_REQ = 8;
    localparam int unsigned RR_IDXW    = 3;

    typedef struct packed {
        logic               any;
        logic [RR_IDXW-1:0] idx;
    } rr_pick_t;

    function automatic logic [METHOD_ID_MSB:METHOD_ID_LSB] method_id(
        input logic [INDICATION_WIDTH-1:0] msg
    );
        return msg[METHOD_ID_MSB:METHOD_ID_LSB];
    endfunction

    // First set bit of valid scanning cyclically from last+1 over nreq entries.
    function automatic rr_pick_t rr_pick(
        input logic [RR_MAX_REQ-1:0] valid,
        input logic [RR_IDXW-1:0]    last,
        input int unsigned           nreq
    );
        rr_pick_t    r;
        int unsigned idx;
        r.any = 1'b0;
        r.idx = '0;
        for (int unsigned k = 1; k <= RR_MAX_REQ; k++) begin
            idx = (32'(last) + k) % nreq;
            if (k <= nreq && !r.any && valid[idx]) begin
                r.any = 1'b1;
                r.idx = idx[RR_IDXW-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/indication_pipe_slot.sv
// One-entry message buffer; an enqueue in the same cycle as a dequeue reloads it.
module indication_pipe_slot
    import indication_pkg::*;
#(
    parameter int unsigned WIDTH = INDICATION_WIDTH
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             enq,
    input  logic             deq,
    input  logic [WIDTH-1:0] enq_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (enq) begin
            valid_d = 1'b1;
            data_d  = enq_data;
        end else if (deq) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/indication_pipe_arbiter.sv
// Round-robin arbiter merging per-interface indication slots into one
// registered pipe enq output stage.
module indication_pipe_arbiter
    import indication_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = INDICATION_WIDTH
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [NREQ-1:0]       req_enq_ena_i,
    input  logic [NREQ*WIDTH-1:0] req_enq_v_i,
    output logic [NREQ-1:0]       req_enq_rdy_o,
    output logic                  pipe_enq_ena_o,
    output logic [WIDTH-1:0]      pipe_enq_v_o,
    input  logic                  pipe_enq_rdy_i
);

    localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]  slot_valid;
    logic [NREQ-1:0]  slot_enq;
    logic [NREQ-1:0]  grant;
    logic [WIDTH-1:0] slot_data [NREQ];

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [IDXW-1:0]  last_q, last_d;

    logic             load;
    logic             any_grant;
    rr_pick_t         pick;

    assign load = !out_valid_q | pipe_enq_rdy_i;

    always_comb begin
        pick      = rr_pick(RR_MAX_REQ'(slot_valid), RR_IDXW'(last_q), NREQ);
        any_grant = load & pick.any;
        grant     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            grant[i] = any_grant && (pick.idx == RR_IDXW'(i));
        end
    end

    // RDY is a function of slot state and downstream ready only, never of ENA.
    assign req_enq_rdy_o = ~slot_valid | grant;
    assign slot_enq      = req_enq_ena_i & req_enq_rdy_o;

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        indication_pipe_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .CLK      (CLK),
            .nRST     (nRST),
            .enq      (slot_enq[i]),
            .deq      (grant[i]),
            .enq_data (req_enq_v_i[i*WIDTH +: WIDTH]),
            .valid    (slot_valid[i]),
            .data     (slot_data[i])
        );
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        last_d      = last_q;
        if (any_grant) begin
            out_valid_d = 1'b1;
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (grant[i]) begin
                    out_data_d = slot_data[i];
                    last_d     = IDXW'(i);
                end
            end
        end else if (out_valid_q && pipe_enq_rdy_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            last_q      <= IDXW'(NREQ - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            last_q      <= last_d;
        end
    end

    assign pipe_enq_ena_o = out_valid_q;
    assign pipe_enq_v_o   = out_data_q;

endmodule

// File: doc/indication_pipe_arbiter.md
# indication_pipe_arbiter

Round-robin arbiter that shares one indication pipe between several generated `*IndicationOutput` blocks. Each requester enqueues 96-bit indication messages (method id in bits 31:0, arguments above it) into a private one-entry slot. The arbiter moves one buffered message per cycle into a registered output stage that drives the shared `pipe$enq` port. It sits between the per-interface indication serializers and the host-facing portal FIFO.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 96: message width in bits.

Ports:
- `CLK`  in  1  clock; all state changes on the rising edge.
- `nRST`  in  1  reset; asynchronous, active-low.
- `req$enq__ENA`  in  NREQ  per-requester enqueue strobe; bit i belongs to requester i.
- `req$enq$v`  in  NREQ*WIDTH  per-requester message; requester i uses bits `[i*WIDTH +: WIDTH]`.
- `req$enq__RDY`  out  NREQ  per-requester ready.
- `pipe$enq__ENA`  out  1  output message valid.
- `pipe$enq$v`  out  WIDTH  output message.
- `pipe$enq__RDY`  in  1  downstream ready.

## Operation
State:
- Per requester: `slot_valid[i]`, `slot_data[i]`.
- Output stage: `out_valid`, `out_data`.
- Arbitration pointer: `last`, log2(NREQ) bits, holding the index of the most recent grant.

Handshake definitions:
- Enqueue i occurs when `req$enq__ENA[i] & req$enq__RDY[i]`.
- Dequeue occurs when `pipe$enq__ENA & pipe$enq__RDY`.
- Asserting ENA while RDY is low is ignored: no state change and no error.

Output stage load condition: `load = !out_valid | pipe$enq__RDY`.

Grant:
- When `load` is high and any `slot_valid` is set, exactly one `grant[i]` goes high.
- The winner i is the first valid slot scanning cyclically from `last+1`.
- If `load` is low, or no slot is valid, no grant is issued.

Rules on the clock edge:
- On a grant: `out_data <= slot_data[i]`, `out_valid <= 1`, `last <= i`.
- On a dequeue with no grant: `out_valid <= 0`.
- On a grant: `slot_valid[i]` clears, unless requester i enqueues in the same cycle, in which case the slot reloads with the new message.

Ready and outputs:
- `req$enq__RDY[i] = !slot_valid[i] | grant[i]`. It never depends on any `req$enq__ENA`.
- `pipe$enq__ENA = out_valid`, `pipe$enq$v = out_data`.
- Payload passes bit-exact: no reordering within a requester and no tagging.

Reset values (applied asynchronously on `nRST` low):
- All `slot_valid` cleared, `out_valid` cleared, `out_data` cleared.
- `last` set to NREQ-1, so requester 0 has first priority.
- Resulting outputs: `pipe$enq__ENA=0`, `pipe$enq$v=0`, `req$enq__RDY` all ones.
- A reset in mid-operation discards buffered and in-flight messages.
- Leaving reset takes effect on the first rising edge with `nRST` high.

## Timing
- Latency: an enqueue at edge N makes the message visible on `pipe$enq$v` with ENA high after edge N+1, provided the output stage can load. Minimum latency is 2 cycles from ENA to output.
- Throughput: 1 message/cycle aggregate; a lone requester also sustains 1 message/cycle via same-cycle slot reload.
- Fairness: with all NREQ slots continuously full, every requester is granted exactly once in any NREQ consecutive grants.
- Backpressure: `pipe$enq__RDY` low holds `out_data` stable and blocks grants. Slots fill, then `req$enq__RDY` drops per requester.
- Combinational paths: `pipe$enq__RDY` → `grant` → `req$enq__RDY`. There is no path from ENA to RDY.

## Structure
- Shared package `indication_pkg`:
  - `WIDTH` default and the method-id field slice `[31:0]`.
  - A function `rr_pick(valid, last)` returning grant index and any-valid flag, reusable by other arbiters.
- Sub-module `indication_pipe_slot`: one-entry buffer with enq/deq/valid/data; instantiated NREQ times.
- Arbiter and output stage live in the top module.

## Test plan
- Reset release: `nRST` low mid-burst with 2 slots full → `pipe$enq__ENA=0`, `pipe$enq$v=0`, `req$enq__RDY=4'b1111` immediately; first post-reset grant goes to requester 0.
- Single requester streaming: requester 2 sends 0x..01..0x..08 on consecutive cycles with `pipe$enq__RDY=1` → 8 outputs in order on consecutive cycles, first one 2 cycles after the first ENA.
- Round-robin: all 4 slots loaded in the same cycle, `pipe$enq__RDY=1` → output order 0,1,2,3. Refill 1 and 3 only → order 1,3.
- Backpressure: `pipe$enq__RDY=0` for 5 cycles with requesters 0 and 1 active → `pipe$enq$v` stable, `req$enq__RDY[1:0]` drop after one accept each. On release, no loss or duplication, order preserved per requester.
- Dequeue and grant in the same cycle: output full, slot 3 full, `pipe$enq__RDY=1` → output replaced by slot 3 data on the next edge and `pipe$enq__ENA` stays high.
- Ignored ENA: requester 1 asserts ENA while its slot is full and not granted → message not captured, and the scoreboard sees only the original.
